// File: rtl/tensor_result_collector_pkg.sv
// ============================================================================
// Module      : tensor_result_collector_pkg
// Description : Shared constants and types for the tensor result collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tensor_result_collector_pkg;

    localparam int TRC_DIM = 4;
    localparam int TRC_DW  = 16;
    localparam logic [TRC_DW-1:0] SAT_LIMIT = 16'd255;

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic [TRC_DW-1:0] clamp_sat8(input logic [TRC_DW-1:0] v);
        return (v > SAT_LIMIT) ? SAT_LIMIT : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tensor_result_collector_bank_store.sv
// ============================================================================
// Module      : trc_bank_store
// Description : NBANK x 16 x DW element store, 4-element row write port and
//               1-element indexed combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trc_bank_store
    import tensor_result_collector_pkg::*;
#(
    parameter int DW    = TRC_DW,
    parameter int NBANK = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [1:0]    i_wrow,
    input  logic [DW-1:0] i_col0,
    input  logic [DW-1:0] i_col1,
    input  logic [DW-1:0] i_col2,
    input  logic [DW-1:0] i_col3,
    input  logic          i_rbank,
    input  logic [3:0]    i_ridx,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [NBANK][TRC_DIM*TRC_DIM];
    logic [DW-1:0] w_row [TRC_DIM];

    assign w_row[0] = i_col0;
    assign w_row[1] = i_col1;
    assign w_row[2] = i_col2;
    assign w_row[3] = i_col3;

    // Contents are deliberately not reset; a bank is only read once FULL.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int c = 0; c < TRC_DIM; c++) begin
                r_mem[i_wbank][{i_wrow, c[1:0]}] <= w_row[c];
            end
        end
    end

    assign o_rdata = r_mem[i_rbank][i_ridx];

endmodule

`default_nettype wire

// File: rtl/tensor_result_collector.sv
// ============================================================================
// Module      : tensor_result_collector
// Description : Ping-pong collector for 4x4 result matrices, streamed out
//               row-major over valid/ready. Optional macro TRC_SAT8_EN
//               clamps output elements to 255 and adds sat_flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_result_collector
    import tensor_result_collector_pkg::*;
#(
    parameter int DW    = TRC_DW,
    parameter int NBANK = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_col0,
    input  logic [DW-1:0] in_col1,
    input  logic [DW-1:0] in_col2,
    input  logic [DW-1:0] in_col3,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_row,
    output logic [1:0]    out_col,
    output logic          out_last,
    output logic          overflow,
    input  logic          clr_ovf
`ifdef TRC_SAT8_EN
    ,
    output logic          sat_flag
`endif
);

    bank_state_t   r_bank_st [NBANK];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_wr_row;
    logic [3:0]    r_rd_idx;

    logic          w_accept;
    logic          w_drop;
    logic          w_load;
    logic          w_load_last;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] w_elem;

    assign in_ready    = (r_bank_st[r_wp] == BANK_FREE) || (r_bank_st[r_wp] == BANK_FILLING);
    assign w_accept    = in_valid & in_ready;
    assign w_drop      = in_valid & ~in_ready;
    // The output register refills whenever it is empty or being consumed.
    assign w_load      = (r_bank_st[r_rp] == BANK_DRAINING) && (!out_valid || out_ready);
    assign w_load_last = w_load && (r_rd_idx == 4'd15);

    trc_bank_store #(
        .DW    (DW),
        .NBANK (NBANK)
    ) u_store (
        .clk     (clk),
        .i_we    (w_accept),
        .i_wbank (r_wp),
        .i_wrow  (r_wr_row),
        .i_col0  (in_col0),
        .i_col1  (in_col1),
        .i_col2  (in_col2),
        .i_col3  (in_col3),
        .i_rbank (r_rp),
        .i_ridx  (r_rd_idx),
        .o_rdata (w_rdata)
    );

`ifdef TRC_SAT8_EN
    logic w_sat;
    assign w_sat  = (w_rdata > DW'(SAT_LIMIT));
    assign w_elem = w_sat ? DW'(SAT_LIMIT) : w_rdata;
`else
    assign w_elem = w_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_st[0] <= BANK_FREE;
            r_bank_st[1] <= BANK_FREE;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_wr_row     <= 2'd0;
            r_rd_idx     <= 4'd0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_row      <= 2'd0;
            out_col      <= 2'd0;
            out_last     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // Write side only ever touches the FREE/FILLING bank, read side
            // only the FULL/DRAINING ones, so the updates never collide.
            if (w_accept) begin
                r_wr_row <= r_wr_row + 2'd1;
                if (r_wr_row == 2'd3) begin
                    r_bank_st[r_wp] <= BANK_FULL;
                    r_wp            <= ~r_wp;
                end else begin
                    r_bank_st[r_wp] <= BANK_FILLING;
                end
            end

            if (w_load) begin
                r_rd_idx <= r_rd_idx + 4'd1;
                if (w_load_last) begin
                    r_bank_st[r_rp] <= BANK_FREE;
                    r_rp            <= ~r_rp;
                    if (r_bank_st[~r_rp] == BANK_FULL) begin
                        r_bank_st[~r_rp] <= BANK_DRAINING;
                    end
                end
            end else if (r_bank_st[r_rp] == BANK_FULL) begin
                r_bank_st[r_rp] <= BANK_DRAINING;
            end

            if (w_load) begin
                out_valid <= 1'b1;
                out_data  <= w_elem;
                out_row   <= r_rd_idx[3:2];
                out_col   <= r_rd_idx[1:0];
                out_last  <= w_load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef TRC_SAT8_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (w_load && w_sat) begin
            sat_flag <= 1'b1;
        end else if (clr_ovf) begin
            sat_flag <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tensor_result_collector.sv
// ============================================================================
// Module      : tb_tensor_result_collector
// Description : Scoreboard bench for tensor_result_collector (TRC_SAT8_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tensor_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_col0, in_col1, in_col2, in_col3;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        overflow;
    logic        clr_ovf;
`ifdef TRC_SAT8_EN
    logic        sat_flag;
`endif

    tensor_result_collector #(.DW(16), .NBANK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_col0   (in_col0),
        .in_col1   (in_col1),
        .in_col2   (in_col2),
        .in_col3   (in_col3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef TRC_SAT8_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   beats = 0;
    int   win_first = -1;
    int   win_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] v);
`ifdef TRC_SAT8_EN
        return (v > 16'd255) ? 16'd255 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    logic        hold_v = 1'b0;
    logic [15:0] hold_d;
    logic [1:0]  hold_r, hold_c;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_d);
                chk("stall_row", out_row, hold_r);
                chk("stall_col", out_col, hold_c);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_row", out_row, e.r);
                    chk("out_col", out_col, e.c);
                    chk("out_last", out_last, e.l);
                end
                beats++;
                if (win_first < 0) win_first = cyc;
                win_last = cyc;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_r = out_row;
            hold_c = out_col;
        end
    end

    task automatic send_row(input logic [15:0] a, b, c, d);
        in_valid = 1'b1;
        in_col0 = a; in_col1 = b; in_col2 = c; in_col3 = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input int base, input int step);
        logic [15:0] v [4];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_t e;
                v[c] = 16'(base + (r * 4 + c) * step);
                e.d = model_out(v[c]);
                e.r = 2'(r);
                e.c = 2'(c);
                e.l = (r == 3) && (c == 3);
                sb.push_back(e);
            end
            chk("in_ready_row", in_ready, 1);
            send_row(v[0], v[1], v[2], v[3]);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_left", sb.size(), 0);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        in_col0 = '0; in_col1 = '0; in_col2 = '0; in_col3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef TRC_SAT8_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Single matrix 1..16 and output latency
        out_ready = 1'b1;
        send_matrix(1, 1);
        @(negedge clk);
        chk("lat_edge0", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("lat_edge1", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("lat_edge2", out_valid, 1);
        wait_drain(100);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", out_valid, 0);

        // Back-to-back matrices, no bubble across the bank switch
        beats = 0; win_first = -1; win_last = -1;
        send_matrix(100, 3);
        send_matrix(500, 5);
        wait_drain(100);
        chk("b2b_beats", beats, 32);
        chk("b2b_span", win_last - win_first + 1, 32);

        // Both banks full: drop, overflow, clear, then intact drain
        out_ready = 1'b0;
        send_matrix(50, 2);
        send_matrix(900, 1);
        @(posedge clk); #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        send_row(16'd7, 16'd7, 16'd7, 16'd7);
        chk("ovf_set", overflow, 1);
        @(posedge clk); #1;
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);
        out_ready = 1'b1;
        wait_drain(100);

        // Random consumer stalls
        out_ready = 1'b0;
        send_matrix(1, 1);
        send_matrix(2000, 11);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain(100);

        // Reset mid-fill discards the partial matrix
        send_row(16'd60000, 16'd60001, 16'd60002, 16'd60003);
        send_row(16'd60004, 16'd60005, 16'd60006, 16'd60007);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        send_matrix(300, 3);
        wait_drain(100);

`ifdef TRC_SAT8_EN
        // Elements 200 and 915 lead the matrix; 915 and above clamp
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("sat_pre", sat_flag, 0);
        send_matrix(200, 715);
        wait_drain(100);
        chk("sat_set", sat_flag, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("end_valid", out_valid, 0);
        chk("end_sb", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
